mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 25 ++
 rtl/bit_slot_timer.sv | 35 +++
 rtl/mux_scan_sequencer.sv | 159 +++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux scan sequencer and its slot timer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mux_scan_pkg;

  localparam int WORD_W    = 8;
  localparam int SEL_W     = 3;
  localparam int NUM_BITS  = 8;
  localparam int BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of the per-slot cycle counter; a 1-cycle slot still needs one bit.
  function automatic int div_cnt_w(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_slot_timer.sv
// Counts the cycles of one bit slot and flags the last cycle of the slot.
// Latency: tc is combinational from the counter; slot length is DIV cycles.
// Backpressure: none; counts whenever enabled, clr has priority over en.
module bit_slot_timer
  import mux_scan_pkg::*;
#(
  parameter int DIV = 1
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = div_cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tc = (div_cnt == LAST);

  // Slot cycle counter, wraps to zero at the end of each slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tc ? '0 : div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Serializes a latched 8-bit word by stepping an external 8:1 mux select and sampling its Y back.
// Latency: bit n valid DIV*(n+1)+1 cycles after the accepting edge; done rides on the last strobe.
// Backpressure: none; start is only taken in IDLE, ignored while busy (MUX_SCAN_PARITY_EN adds a parity bit).
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b0
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  input  logic              y_in,
  output logic [WORD_W-1:0] word_out,
  output logic [SEL_W-1:0]  S,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0]     SEL_FIRST = MSB_FIRST ? SEL_W'(WORD_W - 1) : '0;
  localparam logic [BIT_CNT_W-1:0] LAST_CAP  = BIT_CNT_W'(NUM_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] ALL_CAP   = BIT_CNT_W'(NUM_BITS);

  state_t               state;
  state_t               state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 tc;
  logic                 y_q;
  logic                 cap_q;
  logic                 accept;
  logic                 timer_clr;
  logic                 timer_en;
  logic                 capture;
  logic                 par_emit;
  logic                 out_load;
  logic                 out_bit;

  bit_slot_timer #(
    .DIV (DIV)
  ) u_slot_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (tc)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    capture   = 1'b0;
    par_emit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          timer_clr = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Once all 8 samples are in, spend one cycle pushing the last one out
        // so done lines up with its strobe.
        if (bit_cnt == ALL_CAP) begin
`ifdef MUX_SCAN_PARITY_EN
          timer_clr = 1'b1;
          state_nxt = PARITY;
`else
          state_nxt = DONE;
`endif
        end else begin
          timer_en = 1'b1;
          capture  = tc;
        end
      end
      PARITY: begin
`ifdef MUX_SCAN_PARITY_EN
        timer_en = 1'b1;
        if (tc) begin
          par_emit  = 1'b1;
          state_nxt = DONE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Serial output source: parity goes straight out, data bits come from the sample stage
  always_comb begin
    out_load = cap_q | par_emit;
    out_bit  = par_emit ? ^word_out : y_q;
  end

  // Latch the word, then walk the select one slot at a time without wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_out <= '0;
      S        <= '0;
      bit_cnt  <= '0;
    end else if (accept) begin
      word_out <= data_in;
      S        <= SEL_FIRST;
      bit_cnt  <= '0;
    end else if (capture) begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      if (bit_cnt != LAST_CAP) begin
        S <= MSB_FIRST ? S - SEL_W'(1) : S + SEL_W'(1);
      end
    end
  end

  // Sample y_in at slot end, then register it onto the serial output with status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= 1'b0;
      cap_q     <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cap_q <= capture;
      if (capture) begin
        y_q <= y_in;
      end
      bit_valid <= out_load;
      if (out_load) begin
        bit_out <= out_bit;
      end
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: two sequencers (LSB-first DIV=1, MSB-first DIV=3), each closed through an 8:1 mux.
// Latency: strobe and done timing checked against the accepting edge.
// Backpressure: start re-pulses and held start exercised against the IDLE-only acceptance.
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [7:0] data_a, data_b;
  logic [7:0] word_a, word_b;
  logic [2:0] s_a, s_b;
  logic       y_a, y_b;
  logic       bo_a, bo_b, bv_a, bv_b, busy_a, busy_b, done_a, done_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8:1 mux model: Y = I[S]
  assign y_a = word_a[s_a];
  assign y_b = word_b[s_b];

  mux_scan_sequencer #(.DIV(1), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_a), .y_in(y_a),
    .word_out(word_a), .S(s_a), .bit_out(bo_a), .bit_valid(bv_a), .busy(busy_a), .done(done_a)
  );

  mux_scan_sequencer #(.DIV(3), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_b), .y_in(y_b),
    .word_out(word_b), .S(s_b), .bit_out(bo_b), .bit_valid(bv_b), .busy(busy_b), .done(done_b)
  );

  // Activity logs, sampled just after each rising edge
  logic       bits_a[$], bits_b[$];
  int         vq_a[$], vq_b[$], dq_a[$], dq_b[$];
  logic [2:0] sq_a[$], sq_b[$];

  always @(posedge clk) begin
    #1;
    if (bv_a === 1'b1) begin bits_a.push_back(bo_a); vq_a.push_back(cyc); end
    if (done_a === 1'b1) dq_a.push_back(cyc);
    if (busy_a === 1'b1) sq_a.push_back(s_a);
    if (bv_b === 1'b1) begin bits_b.push_back(bo_b); vq_b.push_back(cyc); end
    if (done_b === 1'b1) dq_b.push_back(cyc);
    if (busy_b === 1'b1) sq_b.push_back(s_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_logs();
    bits_a.delete(); vq_a.delete(); dq_a.delete(); sq_a.delete();
    bits_b.delete(); vq_b.delete(); dq_b.delete(); sq_b.delete();
  endtask

  // Pulse start for one cycle from a falling edge; returns the accepting edge's cycle number
  task automatic start_scan(input string tag, input int which, input logic [7:0] d, output int kacc);
    if (which == 0) begin data_a = d; start_a = 1'b1; end
    else            begin data_b = d; start_b = 1'b1; end
    @(negedge clk);
    kacc = cyc;
    if (which == 0) start_a = 1'b0; else start_b = 1'b0;
    chk({tag, "_accept_busy"}, (which == 0) ? busy_a : busy_b, 1);
  endtask

  task automatic wait_idle(input string tag, input int which, input int budget);
    int n = 0;
    while (((which == 0) ? busy_a : busy_b) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, (which == 0) ? busy_a : busy_b, 0);
  endtask

  task automatic check_scan(input string tag, input int which, input logic [7:0] word,
                            input int div, input bit msb, input int kacc);
    logic       bq[$];
    int         vq[$];
    int         dq[$];
    logic [2:0] sq[$];
    logic [7:0] w;
    logic       eb;
    int         j;
    w = word;
    if (which == 0) begin bq = bits_a; vq = vq_a; dq = dq_a; sq = sq_a; end
    else            begin bq = bits_b; vq = vq_b; dq = dq_b; sq = sq_b; end
    chk($sformatf("%s_nstrobe", tag), bq.size(), NBITS);
    for (int n = 0; n < NBITS && n < bq.size(); n++) begin
      eb = (n < 8) ? w[msb ? 7 - n : n] : ^w;
      chk($sformatf("%s_bit%0d", tag, n), bq[n], eb);
      chk($sformatf("%s_tstrobe%0d", tag, n), vq[n], kacc + 1 + (n + 1) * div);
    end
    chk($sformatf("%s_ndone", tag), dq.size(), 1);
    if (dq.size() > 0 && vq.size() > 0)
      chk($sformatf("%s_tdone", tag), dq[0], vq[vq.size() - 1]);
    chk($sformatf("%s_nbusy", tag), sq.size(), NBITS * div + 2);
    for (int c = 0; c < sq.size() && c < NBITS * div + 2; c++) begin
      j = (c < 8 * div) ? c / div : 7;
      chk($sformatf("%s_sel%0d", tag, c), sq[c], msb ? 7 - j : j);
    end
    chk($sformatf("%s_word", tag), (which == 0) ? word_a : word_b, w);
  endtask

  initial begin
    int k, k2, d, n;

    // Reset held 3 cycles with start asserted: everything stays zero
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1; data_a = 8'hAA; data_b = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_a%0d", i), {word_a, s_a, bo_a, bv_a, busy_a, done_a}, 0);
      chk($sformatf("rst_b%0d", i), {word_b, s_b, bo_b, bv_b, busy_b, done_b}, 0);
    end
    start_a = 1'b0; start_b = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy_a", busy_a, 0);
    chk("post_rst_strobes", bits_a.size() + bits_b.size(), 0);

    // LSB-first, DIV=1, 0xB4
    clr_logs();
    start_scan("lsb", 0, 8'hB4, k);
    wait_idle("lsb", 0, 40);
    check_scan("lsb", 0, 8'hB4, 1, 1'b0, k);

    // MSB-first, DIV=3, 0xB4
    clr_logs();
    start_scan("msb", 1, 8'hB4, k);
    wait_idle("msb", 1, 80);
    check_scan("msb", 1, 8'hB4, 3, 1'b1, k);

    // Odd-weight word (parity bit 1 when the feature is built in)
    clr_logs();
    start_scan("w07", 0, 8'h07, k);
    wait_idle("w07", 0, 40);
    check_scan("w07", 0, 8'h07, 1, 1'b0, k);

    // start re-pulsed mid-scan with new data: original word completes untouched
    clr_logs();
    start_scan("rob", 1, 8'hB4, k);
    repeat (4) @(negedge clk);
    start_b = 1'b1; data_b = 8'hFF;
    repeat (3) @(negedge clk);
    start_b = 1'b0;
    wait_idle("rob", 1, 80);
    check_scan("rob", 1, 8'hB4, 3, 1'b1, k);

    // start held high: restart only via IDLE, word changes only at acceptance
    clr_logs();
    data_a = 8'h3C; start_a = 1'b1;
    @(negedge clk);
    data_a = 8'hC3;
    n = 0;
    while (!done_a && n < 40) begin @(negedge clk); n++; end
    chk("b2b_done1", done_a, 1);
    chk("b2b_word_in_scan", word_a, 8'h3C);
    d = cyc;
    @(negedge clk);
    chk("b2b_gap_busy", busy_a, 0);
    chk("b2b_gap_word", word_a, 8'h3C);
    clr_logs();
    @(negedge clk);
    k2 = cyc;
    start_a = 1'b0;
    chk("b2b_rebusy", busy_a, 1);
    chk("b2b_gap_len", k2, d + 2);
    wait_idle("b2b", 0, 40);
    check_scan("b2b", 0, 8'hC3, 1, 1'b0, k2);

    // Reset after the 4th strobe: cleared outputs, no further strobes, no done
    clr_logs();
    start_scan("mrst", 1, 8'hB4, k);
    n = 0;
    while (bits_b.size() < 4 && n < 100) begin @(negedge clk); n++; end
    chk("mrst_4th", bits_b.size(), 4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_outs", {word_b, s_b, bo_b, bv_b, busy_b, done_b}, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mrst_nstrobe", bits_b.size(), 4);
    chk("mrst_ndone", dq_b.size(), 0);
    chk("mrst_busy", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
